alu_seq: RTL and testbench

- Multi-byte sequencer for the 8-bit combinational ALU.
- Accepts one NBYTES-wide operation from a requester over a valid/ready handshake.
- Runs the ALU one byte per cycle, chaining carry between bytes, and returns the full-width result and final carry over a second valid/ready handshake.
- Sits between the register-file/control path and the single shared ALU instance, so wide arithmetic, shifts and bitwise ops reuse one 8-bit datapath.

---
 rtl/alu_seq.sv | 117 +++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-byte sequencer: runs one wide operation through the shared 8-bit ALU,
// one byte per cycle with the carry chained between bytes.
module alu_seq #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES,
    localparam int IW     = $clog2(NBYTES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [3:0]   req_op,
    input  logic         req_xy,
    input  logic         req_cin,
    input  logic         req_msb_first,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_q,
    output logic         rsp_cout,
    output logic         rsp_zero,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_xy,
    output logic         alu_cin,
    input  logic [7:0]   alu_q,
    input  logic         alu_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_r, b_r, res, res_nx;
    logic [3:0]    op_r;
    logic          xy_r, msb_r, carry;
    logic [IW-1:0] idx, p;
    logic          last;

    assign last      = (idx == IW'(NBYTES - 1));
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        res_nx   = res;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_op   = 4'h0;
        alu_xy   = 1'b0;
        alu_cin  = 1'b0;
        p        = msb_r ? (IW'(NBYTES - 1) - idx) : idx;
        case (state)
            IDLE: if (req_valid) state_nx = RUN;
            RUN: begin
                alu_a  = a_r[8*p +: 8];
                alu_b  = b_r[8*p +: 8];
                alu_xy = xy_r;
                alu_cin = carry;
                alu_op = op_r;
                // Adder-class ops switch to their carry-consuming form after byte 0.
                if (op_r[3:2] == 2'b10 && idx != '0) alu_op[0] = 1'b1;
                res_nx[8*p +: 8] = alu_q;
                if (last) state_nx = DONE;
            end
            DONE: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            xy_r     <= 1'b0;
            msb_r    <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            res      <= '0;
            rsp_q    <= '0;
            rsp_cout <= 1'b0;
            rsp_zero <= 1'b1;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_r   <= req_a;
                        b_r   <= req_b;
                        op_r  <= req_op;
                        xy_r  <= req_xy;
                        msb_r <= req_msb_first;
                        carry <= req_cin;
                        idx   <= '0;
                        res   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= alu_cout;
                    if (last) begin
                        rsp_q    <= res_nx;
                        rsp_cout <= alu_cout;
                        rsp_zero <= (res_nx == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural 8-bit ALU plus a full-width reference model.
module tb_alu_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic [3:0]   req_op;
    logic         req_xy, req_cin, req_msb_first;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_q;
    logic         rsp_cout, rsp_zero;
    logic [7:0]   alu_a, alu_b, alu_q;
    logic [3:0]   alu_op;
    logic         alu_xy, alu_cin, alu_cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_xy(req_xy),
        .req_cin(req_cin), .req_msb_first(req_msb_first),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_xy(alu_xy),
        .alu_cin(alu_cin), .alu_q(alu_q), .alu_cout(alu_cout)
    );

    // Shared 8-bit ALU: sub carry means "no borrow", shifts pass bits through carry.
    always_comb begin
        logic [8:0] t;
        t        = 9'h000;
        alu_q    = 8'h00;
        alu_cout = 1'b0;
        case (alu_op)
            4'b0000: begin alu_q = alu_a & alu_b; alu_cout = alu_cin; end
            4'b0001: begin alu_q = alu_a | alu_b; alu_cout = alu_cin; end
            4'b0010: begin alu_q = alu_a ^ alu_b; alu_cout = alu_cin; end
            4'b1000: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_q = t[7:0]; alu_cout = t[8]; end
            4'b1001: begin t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin}; alu_q = t[7:0]; alu_cout = t[8]; end
            4'b1010: begin alu_q = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
            4'b1011: begin
                alu_q    = alu_a - alu_b - {7'h00, ~alu_cin};
                alu_cout = ({1'b0, alu_a} >= ({1'b0, alu_b} + {8'h00, ~alu_cin}));
            end
            4'b1100: begin
                if (alu_xy) begin alu_q = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
                else        begin alu_q = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
            end
            default: ;
        endcase
    end

    // Whole-word result {cout, q} from plain W-bit arithmetic.
    function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op, input logic xy, input logic cin);
        logic [W:0] s;
        logic [W:0] ci, nci;
        ci  = {{W{1'b0}}, cin};
        nci = {{W{1'b0}}, ~cin};
        s   = '0;
        case (op)
            4'b0000: s = {cin, a & b};
            4'b0001: s = {cin, a | b};
            4'b0010: s = {cin, a ^ b};
            4'b1000: s = {1'b0, a} + {1'b0, b};
            4'b1001: s = {1'b0, a} + {1'b0, b} + ci;
            4'b1010: s = {(a >= b), a - b};
            4'b1011: s = {({1'b0, a} >= ({1'b0, b} + nci)), a - b - nci[W-1:0]};
            4'b1100: s = xy ? {a[0], cin, a[W-1:1]} : {a[W-1], a[W-2:0], cin};
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input logic xy, input logic cin, input logic msb,
                          input int hold, input bit abort);
        logic [W:0] r;
        int         n, p;
        logic [3:0] eop;
        r = ref_model(a, b, op, xy, cin);
        @(negedge clk);
        req_a = a; req_b = b; req_op = op; req_xy = xy; req_cin = cin; req_msb_first = msb;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0;
                req_a = $urandom; req_b = $urandom; req_cin = ~cin;
            end
            if (abort && k == 2) begin
                rst_n = 1'b0;
                #1;
                chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
                chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
                chk("abort_rsp_q", {32'd0, rsp_q}, 64'd0);
                chk("abort_rsp_zero", {63'd0, rsp_zero}, 64'd1);
                chk("abort_alu_a", {56'd0, alu_a}, 64'd0);
                chk("abort_alu_op", {60'd0, alu_op}, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            p   = msb ? NB - 1 - k : k;
            eop = (k != 0 && op[3:2] == 2'b10) ? (op | 4'b0001) : op;
            chk("run_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("run_req_ready", {63'd0, req_ready}, 64'd0);
            chk("run_alu_a", {56'd0, alu_a}, {56'd0, a[8*p +: 8]});
            chk("run_alu_b", {56'd0, alu_b}, {56'd0, b[8*p +: 8]});
            chk("run_alu_op", {60'd0, alu_op}, {60'd0, eop});
            if (k == NB - 1 && hold > 0) rsp_ready = 1'b0;
        end
        @(negedge clk);
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_q", {32'd0, rsp_q}, {32'd0, r[W-1:0]});
        chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, r[W]});
        chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, (r[W-1:0] == '0)});
        chk("done_alu_a", {56'd0, alu_a}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_q", {32'd0, rsp_q}, {32'd0, r[W-1:0]});
            chk("bp_rsp_cout", {63'd0, rsp_cout}, {63'd0, r[W]});
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        if (hold > 0) begin
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("bp_release_idle", {62'd0, req_ready, rsp_valid}, 64'd2);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic [3:0]   op;
    } req_t;

    initial begin
        req_t       bq[3];
        logic [W:0] expq[$];
        logic [W:0] e, rr;
        int         got, last_acc, qi;
        bit         pend;
        logic [3:0] ops[8];
        logic [3:0] op;
        logic       xy, msb;

        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_op = '0; req_xy = 1'b0; req_cin = 1'b0; req_msb_first = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_q", {32'd0, rsp_q}, 64'd0);
        chk("rst_rsp_cout", {63'd0, rsp_cout}, 64'd0);
        chk("rst_rsp_zero", {63'd0, rsp_zero}, 64'd1);
        chk("rst_alu", {43'd0, alu_a, alu_b, alu_op, alu_xy}, 64'd0);
        rst_n = 1'b1;

        run_op(32'h0000_00FF, 32'h0000_0001, 4'b1000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 4'b1010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'h1122_3344, 32'h0, 4'b1100, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        run_op(32'h8122_3345, 32'h0, 4'b1100, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_op(32'h1234_5678, 32'h0F0F_F0F0, 4'b1001, 1'b0, 1'b1, 1'b0, 5, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 4'b1000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_op(32'h0000_0001, 32'h0000_0001, 4'b1000, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Three requests queued with req_valid held high.
        bq[0] = '{32'h0102_0304, 32'h0505_0505, 4'b1000};
        bq[1] = '{32'h0000_0000, 32'h0000_0002, 4'b1010};
        bq[2] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010};
        @(negedge clk);
        qi = 0; got = 0; last_acc = -1;
        req_a = bq[0].a; req_b = bq[0].b; req_op = bq[0].op;
        req_xy = 1'b0; req_cin = 1'b0; req_msb_first = 1'b0; req_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
            pend = 1'b0;
            if (rsp_valid && expq.size() > 0) begin
                e = expq.pop_front();
                chk("b2b_rsp_q", {32'd0, rsp_q}, {32'd0, e[W-1:0]});
                chk("b2b_rsp_cout", {63'd0, rsp_cout}, {63'd0, e[W]});
                got++;
            end
            if (req_valid && req_ready) begin
                expq.push_back(ref_model(req_a, req_b, req_op, 1'b0, 1'b0));
                if (last_acc >= 0) chk("b2b_gap", 64'(cyc - last_acc), 64'(NB + 2));
                last_acc = cyc;
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                qi++;
                if (qi < 3) begin req_a = bq[qi].a; req_b = bq[qi].b; req_op = bq[qi].op; end
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_count", 64'(got), 64'd3);
        req_valid = 1'b0;

        for (int i = 0; i < 24; i++) begin
            op  = ops[$urandom_range(0, 7)];
            xy  = $urandom_range(0, 1);
            msb = (op == 4'b1100) ? xy : ((op[3] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0);
            run_op($urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom, op, xy,
                   1'($urandom_range(0, 1)), msb, (i % 5 == 0) ? 2 : 0, 1'b0);
        end
        rr = ref_model(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
        run_op(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("zero_and_final", {32'd0, rsp_q}, {32'd0, rr[W-1:0]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
